data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//  Byte-addressable, little-endian data memory for the RV32IM core's load/store path.
//  Executes SB/SH/SW stores on the clock edge and returns LB/LBU/LH/LHU/LW results combinationally.
//  Sits behind the ALU address output; the read result feeds the register-file writeback mux.
// PARAMETERS
//  BASE_ADDR    32'h0200_0000  byte address of word 0
//  DEPTH_WORDS  256            number of 32-bit words (1 KiB); power of two
// PORTS
//  ip_clk                  in   1   clock, rising-edge active
//  ip_rst                  in   1   reset, asynchronous, active-low
//  ip_addr                 in   32  byte address of the access
//  ip_store_data           in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  ip_load_store_bit_ctrl  in   2   access size: 00 byte, 01 half, 10 word, 11 reserved
//  ip_load_sign_ctrl       in   1   0 = sign-extend load, 1 = zero-extend load (LBU/LHU)
//  ip_store_en             in   1   1 = write on this rising edge
//  op_read_data            out  32  load result
// BEHAVIOUR
//  - Reset (ip_rst low, asynchronous): every memory byte is cleared to 0. While reset is asserted, op_read_data = 0 and stores are blocked.
//  - Address decode:
//    - word index = (ip_addr - BASE_ADDR) >> 2
//    - lane = ip_addr[1:0]
//  - Store (rising edge, ip_store_en=1, reset deasserted):
//    - byte: ip_store_data[7:0] -> lane ip_addr[1:0]
//    - half: ip_store_data[15:0] -> lanes {ip_addr[1],0} (low byte) and {ip_addr[1],1}; ip_addr[0] ignored
//    - word: all 4 lanes; ip_addr[1:0] ignored
//    - Other lanes are unchanged.
//    - Size 11: no write.
//  - Load (combinational, zero latency; independent of ip_store_en):
//    - byte: selected lane, extended to 32 bits per ip_load_sign_ctrl
//    - half: aligned half selected by ip_addr[1] (ip_addr[0] ignored), extended to 32 bits per ip_load_sign_ctrl
//    - word: full word; ip_load_sign_ctrl ignored
//    - Size 11: returns 32'h0.
//  - Read-during-write to the same address: op_read_data shows the old contents until the edge and the new contents after it (no bypass).
//  - Extension rule: the sign bit is bit 7 (byte) or bit 15 (half) of the selected data.
// CONFIGURATION
//  DATA_MEM_RANGE_CHECK_EN
//    defined: an address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) suppresses the store and forces op_read_data = 32'h0.
//    undefined: no range check; the word index wraps modulo DEPTH_WORDS (upper address bits ignored).
// STRUCTURE
//  - Shared package data_mem_pkg:
//    - localparams SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10
//    - LOAD_SIGNED=1'b0, LOAD_UNSIGNED=1'b1
//    - default BASE_ADDR
//  - Storage: one reg [7:0] array per byte lane, i.e. 4 banks of DEPTH_WORDS entries.
//  - Sub-module data_mem_load_ext: lane select plus sign/zero extension; pure combinational.
//    Inputs: 32-bit word, lane, size, sign ctrl. Output: 32-bit result.
// TESTING
//  Hold reset, release it, then store (each store on its own clock edge), then load; all addresses relative to 0x0200_0000.
//  1. SB 0x08EF965D @+0x0; then LB signed @+0x0 -> 0x0000005D; LW @+0x0 -> 0x0000005D (other lanes still 0).
//  2. SB 0xD9A438B8 @+0x4; LBU @+0x4 -> 0x000000B8; LB signed @+0x4 -> 0xFFFFFFB8.
//  3. SH 0x050B725A @+0x8 and SH 0x5ED7C51F @+0xC.
//     LHU @+0x8 -> 0x0000725A.
//     LH signed @+0xC -> 0xFFFFC51F.
//     LHU @+0xC -> 0x0000C51F.
//  4. SW 0x12345678 @+0x10 and SW 0x87654321 @+0x14.
//     LW @+0x14 -> 0x87654321, for either ip_load_sign_ctrl value.
//     LB @+0x13 -> 0x00000012.
//     LH @+0x12 -> 0x00001234.
//  5. Assert ip_rst low mid-run (asynchronously, between edges).
//     op_read_data -> 0 immediately.
//     After release, LW @+0x14 -> 0x00000000.
//     A store attempted during reset has no effect.
//  6. Range/wrap, with DATA_MEM_RANGE_CHECK_EN defined:
//     SW @0x0300_0000 -> no write; load there -> 0.
//     Undefined: SW 0xA5A5A5A5 @BASE_ADDR+4*DEPTH_WORDS -> LW @+0x0 -> 0xA5A5A5A5.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared constants and helpers for the RV32IM data memory.
// Access-size and load-extension encodings, default address map, lane-enable helper.
package data_mem_pkg;

    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;

    localparam logic        LOAD_SIGNED   = 1'b0;
    localparam logic        LOAD_UNSIGNED = 1'b1;

    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h0200_0000;
    localparam int          DEFAULT_DEPTH_WORDS = 256;

    // Byte-lane write enables; half stores ignore lane[0], word stores ignore both lane bits.
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lane;
            SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// Load/store bus between the core (master) and the data memory (slave).
interface data_mem_if;

    logic [31:0] ip_addr;
    logic [31:0] ip_store_data;
    logic [1:0]  ip_load_store_bit_ctrl;
    logic        ip_load_sign_ctrl;
    logic        ip_store_en;
    logic [31:0] op_read_data;

    modport master (
        output ip_addr,
        output ip_store_data,
        output ip_load_store_bit_ctrl,
        output ip_load_sign_ctrl,
        output ip_store_en,
        input  op_read_data
    );

    modport slave (
        input  ip_addr,
        input  ip_store_data,
        input  ip_load_store_bit_ctrl,
        input  ip_load_sign_ctrl,
        input  ip_store_en,
        output op_read_data
    );

endinterface

// File: rtl/data_mem_load_ext.sv
// Load lane select with sign/zero extension; purely combinational.
module data_mem_load_ext
    import data_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ctrl,
    output logic [31:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = '0;
        sel_half = '0;
        result   = '0;
        case (lane)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        sel_half = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: result = (sign_ctrl == LOAD_UNSIGNED) ? {24'h0, sel_byte}
                                                             : {{24{sel_byte[7]}}, sel_byte};
            SIZE_HALF: result = (sign_ctrl == LOAD_UNSIGNED) ? {16'h0, sel_half}
                                                             : {{16{sel_half[15]}}, sel_half};
            SIZE_WORD: result = word;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory: clocked stores, combinational loads.
// Define DATA_MEM_RANGE_CHECK_EN to reject accesses outside the mapped window instead of wrapping.
module data_memory
    import data_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
    input  logic           ip_clk,
    input  logic           ip_rst,
    data_mem_if.slave      bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      offset;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             in_range;
    logic             wr_en;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [31:0]      rd_word;
    logic [31:0]      ext_result;
    logic             unused_offset_bits;

    assign offset   = bus.ip_addr - BASE_ADDR;
    assign word_idx = offset[IDX_W+1:2];
    assign lane     = bus.ip_addr[1:0];

    // Bits above the index only matter when the window is enforced.
    assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};

`ifdef DATA_MEM_RANGE_CHECK_EN
    assign in_range = (offset < 32'(4 * DEPTH_WORDS));
`else
    assign in_range = 1'b1;
`endif

    assign be    = lane_enables(bus.ip_load_store_bit_ctrl, lane);
    assign wr_en = bus.ip_store_en && in_range;

    // Replicate the right-justified store data so every enabled lane sees its byte.
    always_comb begin
        wdata = '0;
        case (bus.ip_load_store_bit_ctrl)
            SIZE_BYTE: wdata = {4{bus.ip_store_data[7:0]}};
            SIZE_HALF: wdata = {2{bus.ip_store_data[15:0]}};
            SIZE_WORD: wdata = bus.ip_store_data;
            default:   wdata = '0;
        endcase
    end

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];

        always_ff @(posedge ip_clk or negedge ip_rst) begin
            if (!ip_rst) begin
                for (int i = 0; i < DEPTH_WORDS; i++) begin
                    mem[i] <= '0;
                end
            end else if (wr_en && be[l]) begin
                mem[word_idx] <= wdata[8*l +: 8];
            end
        end

        assign rd_word[8*l +: 8] = mem[word_idx];
    end

    data_mem_load_ext u_load_ext (
        .word      (rd_word),
        .lane      (lane),
        .size      (bus.ip_load_store_bit_ctrl),
        .sign_ctrl (bus.ip_load_sign_ctrl),
        .result    (ext_result)
    );

    assign bus.op_read_data = (!ip_rst || !in_range) ? 32'h0 : ext_result;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: expected load values queued at drive time, popped at sample time.
module tb_data_memory;
    import data_mem_pkg::*;

    localparam logic [31:0] BASE  = 32'h0200_0000;
    localparam int          DEPTH = 256;

    logic ip_clk = 1'b0;
    logic ip_rst = 1'b0;

    always #5 ip_clk = ~ip_clk;

    data_mem_if bus();

    data_memory #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .ip_clk (ip_clk),
        .ip_rst (ip_rst),
        .bus    (bus)
    );

    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample(input string tag);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got %h expected <empty scoreboard>", tag, bus.op_read_data);
        end else begin
            check_eq(tag, bus.op_read_data, exp_q.pop_front());
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] size, input logic sign, input logic en);
        bus.ip_addr                = addr;
        bus.ip_store_data          = data;
        bus.ip_load_store_bit_ctrl = size;
        bus.ip_load_sign_ctrl      = sign;
        bus.ip_store_en            = en;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        @(negedge ip_clk);
        drive(addr, data, size, LOAD_SIGNED, 1'b1);
        @(posedge ip_clk);
        #1;
        bus.ip_store_en = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic sign, input logic [31:0] exp);
        @(negedge ip_clk);
        drive(addr, 32'h0, size, sign, 1'b0);
        exp_q.push_back(exp);
        #1;
        sample(tag);
    endtask

    initial begin
        drive(BASE + 32'h14, 32'h0, SIZE_WORD, LOAD_SIGNED, 1'b0);
        repeat (2) @(posedge ip_clk);
        exp_q.push_back(32'h0);
        #1;
        sample("reset_hold");
        @(negedge ip_clk);
        ip_rst = 1'b1;
        load("reset_state", BASE + 32'h0, SIZE_WORD, LOAD_SIGNED, 32'h0);

        store(BASE + 32'h0, 32'h08EF965D, SIZE_BYTE);
        load("lb_0", BASE + 32'h0, SIZE_BYTE, LOAD_SIGNED, 32'h0000005D);
        load("lw_0", BASE + 32'h0, SIZE_WORD, LOAD_SIGNED, 32'h0000005D);

        store(BASE + 32'h4, 32'hD9A438B8, SIZE_BYTE);
        load("lbu_4", BASE + 32'h4, SIZE_BYTE, LOAD_UNSIGNED, 32'h000000B8);
        load("lb_4", BASE + 32'h4, SIZE_BYTE, LOAD_SIGNED, 32'hFFFFFFB8);

        store(BASE + 32'h8, 32'h050B725A, SIZE_HALF);
        store(BASE + 32'hC, 32'h5ED7C51F, SIZE_HALF);
        load("lhu_8", BASE + 32'h8, SIZE_HALF, LOAD_UNSIGNED, 32'h0000725A);
        load("lh_c", BASE + 32'hC, SIZE_HALF, LOAD_SIGNED, 32'hFFFFC51F);
        load("lhu_c", BASE + 32'hC, SIZE_HALF, LOAD_UNSIGNED, 32'h0000C51F);

        store(BASE + 32'h10, 32'h12345678, SIZE_WORD);
        store(BASE + 32'h14, 32'h87654321, SIZE_WORD);
        load("lw_14_s", BASE + 32'h14, SIZE_WORD, LOAD_SIGNED, 32'h87654321);
        load("lw_14_u", BASE + 32'h14, SIZE_WORD, LOAD_UNSIGNED, 32'h87654321);
        load("lb_13", BASE + 32'h13, SIZE_BYTE, LOAD_SIGNED, 32'h00000012);
        load("lh_12", BASE + 32'h12, SIZE_HALF, LOAD_SIGNED, 32'h00001234);

        store(BASE + 32'h10, 32'hFFFFFFFF, 2'b11);
        load("rsvd_store", BASE + 32'h10, SIZE_WORD, LOAD_SIGNED, 32'h12345678);
        load("rsvd_load", BASE + 32'h10, 2'b11, LOAD_SIGNED, 32'h0);

        store(BASE + 32'h11, 32'h000000AB, SIZE_BYTE);
        load("sb_merge", BASE + 32'h10, SIZE_WORD, LOAD_SIGNED, 32'h1234AB78);
        store(BASE + 32'h17, 32'h00009988, SIZE_HALF);
        load("sh_odd", BASE + 32'h14, SIZE_WORD, LOAD_SIGNED, 32'h99884321);
        load("lh_16", BASE + 32'h16, SIZE_HALF, LOAD_SIGNED, 32'hFFFF9988);
        load("lb_15u", BASE + 32'h15, SIZE_BYTE, LOAD_UNSIGNED, 32'h00000043);

        @(negedge ip_clk);
        drive(BASE + 32'h20, 32'hCAFEBABE, SIZE_WORD, LOAD_SIGNED, 1'b1);
        exp_q.push_back(32'h0);
        #1;
        sample("rdw_old");
        @(posedge ip_clk);
        #1;
        bus.ip_store_en = 1'b0;
        exp_q.push_back(32'hCAFEBABE);
        sample("rdw_new");

        load("pre_rst", BASE + 32'h14, SIZE_WORD, LOAD_SIGNED, 32'h99884321);
        #1;
        ip_rst = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        sample("rst_async");
        drive(BASE + 32'h18, 32'hDEADBEEF, SIZE_WORD, LOAD_SIGNED, 1'b1);
        @(posedge ip_clk);
        #1;
        bus.ip_store_en = 1'b0;
        @(negedge ip_clk);
        ip_rst = 1'b1;
        load("post_rst_14", BASE + 32'h14, SIZE_WORD, LOAD_SIGNED, 32'h0);
        load("post_rst_18", BASE + 32'h18, SIZE_WORD, LOAD_SIGNED, 32'h0);
        load("post_rst_20", BASE + 32'h20, SIZE_WORD, LOAD_SIGNED, 32'h0);

`ifdef DATA_MEM_RANGE_CHECK_EN
        store(32'h0300_0000, 32'hA5A5A5A5, SIZE_WORD);
        load("oor_load", 32'h0300_0000, SIZE_WORD, LOAD_SIGNED, 32'h0);
        load("oor_no_alias", BASE + 32'h0, SIZE_WORD, LOAD_SIGNED, 32'h0);
`else
        store(BASE + 32'(4 * DEPTH), 32'hA5A5A5A5, SIZE_WORD);
        load("wrap_load", BASE + 32'h0, SIZE_WORD, LOAD_SIGNED, 32'hA5A5A5A5);
        load("wrap_byte", BASE + 32'h3, SIZE_BYTE, LOAD_SIGNED, 32'hFFFFFFA5);
`endif

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
